// File: rtl/write_buffer_drain.sv
// Drains a write buffer into a simple valid/ready memory write port, one entry per
// handshake, and counts the completed writes.
module write_buffer_drain #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int WORDSIZE = ADDR_W + DATA_W / 8 + DATA_W
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  buf_empty,
    output logic                  buf_rd,
    input  logic [WORDSIZE-1:0]   buf_dataout,
    output logic                  mem_valid,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    output logic [DATA_W/8-1:0]   mem_wstrb,
    input  logic                  mem_ready,
    output logic                  idle,
    output logic [15:0]           wr_count
);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] wr_count_q, wr_count_d;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= IDLE;
            wr_count_q <= '0;
        end else begin
            state_q    <= state_d;
            wr_count_q <= wr_count_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        wr_count_d = wr_count_q;
        buf_rd     = 1'b0;
        // Fetch the next entry whenever the port is free or being freed this cycle.
        case (state_q)
            IDLE: begin
                if (!buf_empty && !reset) begin
                    buf_rd  = 1'b1;
                    state_d = SEND;
                end
            end
            SEND: begin
                if (mem_ready) begin
                    wr_count_d = wr_count_q + 16'd1;
                    if (!buf_empty) begin
                        buf_rd  = !reset;
                        state_d = SEND;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign mem_valid = (state_q == SEND);
    assign mem_addr  = buf_dataout[WORDSIZE-1 -: ADDR_W];
    assign mem_wstrb = buf_dataout[DATA_W +: DATA_W/8];
    assign mem_wdata = buf_dataout[DATA_W-1:0];
    assign idle      = (state_q == IDLE) && buf_empty;
    assign wr_count  = wr_count_q;

endmodule

// File: tb/tb_write_buffer_drain.sv
// Directed bench for write_buffer_drain with a small FIFO model standing in for
// the write buffer (entry presented the cycle after buf_rd).
module tb_write_buffer_drain;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int WS     = ADDR_W + DATA_W / 8 + DATA_W;

    logic                clock = 1'b0;
    logic                reset = 1'b1;
    logic                buf_empty;
    logic                buf_rd;
    logic [WS-1:0]       buf_dataout = '0;
    logic                mem_valid;
    logic [ADDR_W-1:0]   mem_addr;
    logic [DATA_W-1:0]   mem_wdata;
    logic [DATA_W/8-1:0] mem_wstrb;
    logic                mem_ready = 1'b0;
    logic                idle;
    logic [15:0]         wr_count;

    int tests  = 0;
    int failed = 0;

    logic [WS-1:0] fifo_mem [0:63];
    int unsigned   wr_ptr = 0;
    int unsigned   rd_ptr = 0;
    logic          stream = 1'b0;
    int unsigned   rd_pulses = 0;
    int unsigned   vld_cycles = 0;

    write_buffer_drain #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .WORDSIZE(WS)) dut (
        .clock       (clock),
        .reset       (reset),
        .buf_empty   (buf_empty),
        .buf_rd      (buf_rd),
        .buf_dataout (buf_dataout),
        .mem_valid   (mem_valid),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_wstrb   (mem_wstrb),
        .mem_ready   (mem_ready),
        .idle        (idle),
        .wr_count    (wr_count)
    );

    always #5 clock = ~clock;

    // In stream mode the buffer looks endlessly full and keeps its last entry.
    assign buf_empty = stream ? 1'b0 : (wr_ptr == rd_ptr);

    always @(posedge clock) begin
        if (buf_rd && !stream) begin
            buf_dataout <= fifo_mem[rd_ptr % 64];
            rd_ptr      <= rd_ptr + 1;
        end
        if (buf_rd)    rd_pulses  <= rd_pulses + 1;
        if (mem_valid) vld_cycles <= vld_cycles + 1;
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic push(input logic [ADDR_W-1:0] a, input logic [DATA_W/8-1:0] s,
                        input logic [DATA_W-1:0] d);
        fifo_mem[wr_ptr % 64] = {a, s, d};
        wr_ptr = wr_ptr + 1;
        #1;
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        mem_ready = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            tests++;
            if (buf_rd !== 1'b0 || mem_valid !== 1'b0 || idle !== 1'b1 || wr_count !== 16'd0) begin
                failed++;
                $display("FAIL reset_state cyc=%0d: buf_rd=%b mem_valid=%b idle=%b wr_count=%0d, required 0 0 1 0",
                         i, buf_rd, mem_valid, idle, wr_count);
            end
        end
        reset = 1'b0;
        mem_ready = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        tests++;
        if (wr_count !== 16'd0 || mem_valid !== 1'b0) begin
            failed++;
            $display("FAIL ready_while_idle: wr_count=%0d mem_valid=%b, required 0 0", wr_count, mem_valid);
        end
        mem_ready = 1'b0;
    endtask

    task automatic test_single();
        int unsigned rd0, v0;
        do_reset();
        mem_ready = 1'b1;
        rd0 = rd_pulses;
        v0  = vld_cycles;
        push(32'h100, 4'hF, 32'hDEADBEEF);
        tests++;
        if (buf_rd !== 1'b1 || mem_valid !== 1'b0) begin
            failed++;
            $display("FAIL single_rd: buf_rd=%b mem_valid=%b, required 1 0", buf_rd, mem_valid);
        end
        tick();
        tests++;
        if (mem_valid !== 1'b1 || mem_addr !== 32'h100 || mem_wstrb !== 4'hF ||
            mem_wdata !== 32'hDEADBEEF || buf_rd !== 1'b0) begin
            failed++;
            $display("FAIL single_issue: valid=%b addr=%h strb=%h data=%h rd=%b, required 1 00000100 f deadbeef 0",
                     mem_valid, mem_addr, mem_wstrb, mem_wdata, buf_rd);
        end
        tick();
        tests++;
        if (mem_valid !== 1'b0 || wr_count !== 16'd1 || idle !== 1'b1 ||
            rd_pulses - rd0 != 1 || vld_cycles - v0 != 1) begin
            failed++;
            $display("FAIL single_done: valid=%b wr_count=%0d idle=%b rd=%0d vld=%0d, required 0 1 1 1 1",
                     mem_valid, wr_count, idle, rd_pulses - rd0, vld_cycles - v0);
        end
    endtask

    task automatic test_backpressure();
        int unsigned rd0, v0;
        do_reset();
        rd0 = rd_pulses;
        v0  = vld_cycles;
        push(32'h100, 4'hF, 32'hDEADBEEF);
        tick();
        for (int i = 0; i < 5; i++) begin
            tests++;
            if (mem_valid !== 1'b1 || mem_addr !== 32'h100 || mem_wdata !== 32'hDEADBEEF ||
                mem_wstrb !== 4'hF || buf_rd !== 1'b0 || wr_count !== 16'd0) begin
                failed++;
                $display("FAIL stall_hold cyc=%0d: valid=%b addr=%h data=%h strb=%h rd=%b cnt=%0d, required 1 00000100 deadbeef f 0 0",
                         i, mem_valid, mem_addr, mem_wdata, mem_wstrb, buf_rd, wr_count);
            end
            tick();
        end
        mem_ready = 1'b1;
        tick();
        tests++;
        if (mem_valid !== 1'b0 || wr_count !== 16'd1 || rd_pulses - rd0 != 1 || vld_cycles - v0 != 6) begin
            failed++;
            $display("FAIL stall_done: valid=%b wr_count=%0d rd=%0d vld=%0d, required 0 1 1 6",
                     mem_valid, wr_count, rd_pulses - rd0, vld_cycles - v0);
        end
    endtask

    task automatic test_back_to_back();
        int unsigned rd0, v0;
        logic [ADDR_W-1:0]   ea [4] = '{32'h200, 32'h204, 32'h208, 32'h20C};
        logic [DATA_W/8-1:0] es [4] = '{4'h1, 4'h0, 4'hC, 4'hF};
        do_reset();
        mem_ready = 1'b1;
        rd0 = rd_pulses;
        v0  = vld_cycles;
        for (int i = 0; i < 4; i++) fifo_mem[(wr_ptr + i) % 64] = {ea[i], es[i], 32'hA0 + 32'(i)};
        wr_ptr = wr_ptr + 4;
        #1;
        for (int i = 0; i < 4; i++) begin
            tick();
            tests++;
            if (mem_valid !== 1'b1 || mem_addr !== ea[i] || mem_wstrb !== es[i] ||
                mem_wdata !== 32'hA0 + 32'(i) || wr_count !== 16'(i)) begin
                failed++;
                $display("FAIL b2b_entry%0d: valid=%b addr=%h strb=%h data=%h cnt=%0d, required 1 %h %h %h %0d",
                         i, mem_valid, mem_addr, mem_wstrb, mem_wdata, wr_count, ea[i], es[i], 32'hA0 + 32'(i), i);
            end
        end
        tick();
        tests++;
        if (mem_valid !== 1'b0 || wr_count !== 16'd4 || rd_pulses - rd0 != 4 || vld_cycles - v0 != 4 || idle !== 1'b1) begin
            failed++;
            $display("FAIL b2b_done: valid=%b wr_count=%0d rd=%0d vld=%0d idle=%b, required 0 4 4 4 1",
                     mem_valid, wr_count, rd_pulses - rd0, vld_cycles - v0, idle);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        stream    = 1'b1;
        mem_ready = 1'b1;
        #1;
        tick();
        for (int i = 0; i < 65535; i++) tick();
        mem_ready = 1'b0;
        stream    = 1'b0;
        #1;
        tests++;
        if (wr_count !== 16'hFFFF || mem_valid !== 1'b1) begin
            failed++;
            $display("FAIL wrap_preload: wr_count=%h valid=%b, required ffff 1", wr_count, mem_valid);
        end
        mem_ready = 1'b1;
        tick();
        tests++;
        if (wr_count !== 16'h0000 || mem_valid !== 1'b0) begin
            failed++;
            $display("FAIL wrap: wr_count=%h valid=%b, required 0000 0", wr_count, mem_valid);
        end
        mem_ready = 1'b0;
    endtask

    task automatic test_reset_in_send();
        int unsigned rd0;
        do_reset();
        mem_ready = 1'b1;
        push(32'h300, 4'h3, 32'h11111111);
        tick();
        tick();
        mem_ready = 1'b0;
        push(32'h400, 4'h7, 32'h22222222);
        tick();
        push(32'h500, 4'h5, 32'h33333333);
        tests++;
        if (mem_valid !== 1'b1 || mem_addr !== 32'h400 || wr_count !== 16'd1) begin
            failed++;
            $display("FAIL rst_send_setup: valid=%b addr=%h cnt=%0d, required 1 00000400 1",
                     mem_valid, mem_addr, wr_count);
        end
        reset = 1'b1;
        rd0   = rd_pulses;
        #1;
        tests++;
        if (buf_rd !== 1'b0) begin
            failed++;
            $display("FAIL rst_no_rd: buf_rd=%b, required 0", buf_rd);
        end
        tick();
        tests++;
        if (mem_valid !== 1'b0 || wr_count !== 16'd0 || idle !== 1'b0 || rd_pulses - rd0 != 0) begin
            failed++;
            $display("FAIL rst_send: valid=%b wr_count=%0d idle=%b rd=%0d, required 0 0 0 0",
                     mem_valid, wr_count, idle, rd_pulses - rd0);
        end
        reset     = 1'b0;
        mem_ready = 1'b1;
        #1;
        tick();
        tests++;
        if (mem_valid !== 1'b1 || mem_addr !== 32'h500 || mem_wdata !== 32'h33333333) begin
            failed++;
            $display("FAIL rst_no_retry: valid=%b addr=%h data=%h, required 1 00000500 33333333",
                     mem_valid, mem_addr, mem_wdata);
        end
        tick();
        tests++;
        if (mem_valid !== 1'b0 || wr_count !== 16'd1 || idle !== 1'b1) begin
            failed++;
            $display("FAIL rst_drain: valid=%b wr_count=%0d idle=%b, required 0 1 1", mem_valid, wr_count, idle);
        end
        mem_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_backpressure();
        test_back_to_back();
        test_reset_in_send();
        test_wrap();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/write_buffer_drain.md
WRITE_BUFFER_DRAIN -- requirements
Module: write_buffer_drain

Interface
REQ-001 Parameter ADDR_W, 32, memory byte-address width.
REQ-002 Parameter DATA_W, 32, memory data width; multiple of 8.
REQ-003 Parameter WORDSIZE, ADDR_W+DATA_W/8+DATA_W, buffer entry width; entry layout {addr[ADDR_W], wstrb[DATA_W/8], wdata[DATA_W]}, addr in MSBs.
REQ-004 Port clock  input  1  sole clock; all state updates on rising edge.
REQ-005 Port reset  input  1  synchronous, active-high reset.
REQ-006 Port buf_empty  input  1  write buffer empty flag.
REQ-007 Port buf_rd  output  1  write buffer read strobe; buffer presents the entry on buf_dataout the cycle after.
REQ-008 Port buf_dataout  input  WORDSIZE  current buffer output entry; stable until next buf_rd.
REQ-009 Port mem_valid  output  1  memory write request valid.
REQ-010 Port mem_addr  output  ADDR_W  memory write address.
REQ-011 Port mem_wdata  output  DATA_W  memory write data.
REQ-012 Port mem_wstrb  output  DATA_W/8  memory byte enables.
REQ-013 Port mem_ready  input  1  memory accepts request when high with mem_valid.
REQ-014 Port idle  output  1  high when no write in flight and buf_empty high.
REQ-015 Port wr_count  output  16  completed memory writes, wraps modulo 2^16.

Function
REQ-016 Two-state FSM SHALL be used: IDLE, SEND.
REQ-017 buf_rd SHALL be combinational: high iff ~buf_empty and (state IDLE, or state SEND with mem_ready).
REQ-018 IDLE -> SEND SHALL occur on the edge where buf_rd is high; otherwise remain IDLE.
REQ-019 In SEND with mem_ready low, state and outputs SHALL hold unchanged (no buf_rd).
REQ-020 In SEND with mem_ready high: ~buf_empty -> stay SEND (back-to-back, next entry presented next cycle); buf_empty -> IDLE.
REQ-021 mem_valid SHALL equal (state == SEND); mem_valid SHALL never drop before the mem_ready handshake.
REQ-022 mem_addr, mem_wstrb, mem_wdata SHALL be driven directly from the corresponding fields of buf_dataout; they SHALL be stable while mem_valid is high and mem_ready is low.
REQ-023 Latency: buf_empty falls in cycle t while IDLE -> buf_rd in cycle t -> mem_valid high in cycle t+1.
REQ-024 Sustained throughput SHALL be one write per cycle when mem_ready is held high and buffer non-empty.
REQ-025 wr_count SHALL increment by 1 on each cycle with mem_valid & mem_ready; 16'hFFFF + 1 -> 16'h0000.
REQ-026 idle SHALL equal (state == IDLE) & buf_empty.
REQ-027 Entries with wstrb == 0 SHALL still be issued unchanged (no filtering).
REQ-028 mem_ready while mem_valid low SHALL be ignored.

Reset
REQ-029 On reset high at a rising edge: state <= IDLE, wr_count <= 0; mem_valid low from the following cycle.
REQ-030 buf_rd SHALL be held low during any cycle in which reset is high.
REQ-031 Reset asserted in SEND before mem_ready SHALL abandon the in-flight entry (no retry); entry is lost.
REQ-032 After reset, idle SHALL equal buf_empty.

Verification
REQ-033 Reset, buf_empty=1 for 10 cycles -> buf_rd=0, mem_valid=0, idle=1, wr_count=0.
REQ-034 One entry {addr=0x100, wstrb=0xF, wdata=0xDEADBEEF}, mem_ready=1 -> buf_rd 1 cycle, mem_valid 1 cycle next with those values, wr_count=1, back to IDLE.
REQ-035 Same entry, mem_ready low 5 cycles then high -> mem_valid high 6 cycles, outputs constant, single buf_rd, wr_count=1.
REQ-036 Four entries queued, mem_ready=1 -> mem_valid high 4 consecutive cycles, addrs in FIFO order, buf_rd high 4 cycles, wr_count=4.
REQ-037 wr_count preloaded by 65535 handshakes, one more write -> wr_count=0.
REQ-038 Reset asserted in SEND with mem_ready=0 -> next cycle mem_valid=0, state IDLE, wr_count=0, no buf_rd during reset.
